rib_arbiter: RTL and testbench

- Shares one RIB slave-side request channel among NUM_M bus masters: core data port, core fetch port, JTAG debug and UART download.
- Sits between the masters and the address decoder.
- Two arbitration classes: absolute-priority masters (debug/download) and round-robin masters (core ports).
- Sequences each transfer through a req/ready handshake, raises a pipeline hold flag for the core, and bounds every transfer with a timeout.

---
 rtl/tinyriscv_pkg.sv | 17 +
 rtl/rr_picker.sv | 27 ++
 rtl/rib_arbiter.sv | 124 ++++++++++++
 tb/tb_rib_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared bus widths, arbiter state and RIB master indices
package tinyriscv_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemBus     = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int RIB_M_EX   = 0;
    localparam int RIB_M_PC   = 1;
    localparam int RIB_M_JTAG = 2;
    localparam int RIB_M_UART = 3;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - RIB request-channel arbiter: absolute-priority debug masters,
// round-robin core ports, req/ready sequencing with timeout and abort.
module rib_arbiter
    import tinyriscv_pkg::*;
#(
    parameter int               NUM_M     = 4,
    parameter logic [NUM_M-1:0] PRIO_MASK = 4'b1100,
    parameter int               TIMEOUT   = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_M-1:0]                     m_req_i,
    input  logic [NUM_M-1:0]                     m_we_i,
    input  logic [NUM_M-1:0][MemAddrBus-1:0]     m_addr_i,
    input  logic [NUM_M-1:0][MemBus-1:0]         m_wdata_i,
    output logic [MemBus-1:0]                    m_rdata_o,
    output logic [NUM_M-1:0]                     m_gnt_o,
    output logic [NUM_M-1:0]                     m_ready_o,
    output logic                                 s_req_o,
    output logic                                 s_we_o,
    output logic [MemAddrBus-1:0]                s_addr_o,
    output logic [MemBus-1:0]                    s_wdata_o,
    input  logic [MemBus-1:0]                    s_rdata_i,
    input  logic                                 s_ready_i,
    output logic                                 hold_flag_o,
    output logic                                 err_timeout_o
);

    localparam int         IW      = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e     state_q;
    logic [IW-1:0]  owner_q;
    logic [IW-1:0]  rr_ptr_q;
    logic [7:0]     cnt_q;

    logic             busy;
    logic             owner_req;
    logic             owner_prio;
    logic             abort;
    logic             done_ok;
    logic             done_to;
    logic [NUM_M-1:0] prio_req;
    logic [NUM_M-1:0] rr_req;
    logic [NUM_M-1:0] rr_gnt;
    logic [IW-1:0]    win_idx;

    assign busy       = (state_q == ARB_BUSY);
    assign owner_req  = m_req_i[owner_q];
    assign owner_prio = PRIO_MASK[owner_q];
    assign prio_req   = m_req_i & PRIO_MASK;
    assign rr_req     = m_req_i & ~PRIO_MASK;

    // A withdrawn request outranks a simultaneous ready: the master no longer wants the result.
    assign abort   = busy && !owner_req;
    assign done_ok = busy && owner_req && s_ready_i;
    assign done_to = busy && owner_req && !s_ready_i && (cnt_q == TO_LAST);

    rr_picker #(.N(NUM_M), .PW(IW)) u_rr_picker (
        .req_i (rr_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt)
    );

    always_comb begin
        win_idx = '0;
        if (prio_req != '0) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (prio_req[i]) win_idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                if (rr_gnt[i]) win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        m_gnt_o   = '0;
        m_ready_o = '0;
        if (busy) m_gnt_o[owner_q] = 1'b1;
        if (done_ok || done_to) m_ready_o[owner_q] = 1'b1;
    end

    assign m_rdata_o     = done_ok ? s_rdata_i : '0;
    assign err_timeout_o = done_to;
    assign s_req_o       = busy && owner_req;
    assign s_we_o        = busy && m_we_i[owner_q];
    assign s_addr_o      = busy ? m_addr_i[owner_q]  : '0;
    assign s_wdata_o     = busy ? m_wdata_i[owner_q] : '0;
    assign hold_flag_o   = rst_ni && ((busy && owner_prio) || (prio_req != '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    if (m_req_i != '0) begin
                        owner_q <= win_idx;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (abort || done_ok || done_to) begin
                        state_q <= ARB_IDLE;
                        cnt_q   <= '0;
                        if (done_ok && !owner_prio) begin
                            rr_ptr_q <= (owner_q == IW'(NUM_M - 1)) ? '0 : owner_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - table-driven scoreboard bench for rib_arbiter (TIMEOUT=8)
module tb_rib_arbiter;
    import tinyriscv_pkg::*;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] rdata;
        logic [3:0]  gnt;
        logic [3:0]  mrdy;
        logic        sreq;
        logic        hold;
        logic        err;
        logic [31:0] mrdata;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [3:0]                 m_req;
    logic [3:0]                 m_we;
    logic [3:0][MemAddrBus-1:0] m_addr;
    logic [3:0][MemBus-1:0]     m_wdata;
    logic [MemBus-1:0]          m_rdata;
    logic [3:0]                 m_gnt;
    logic [3:0]                 m_ready;
    logic                       s_req;
    logic                       s_we;
    logic [MemAddrBus-1:0]      s_addr;
    logic [MemBus-1:0]          s_wdata;
    logic [MemBus-1:0]          s_rdata;
    logic                       s_ready;
    logic                       hold_flag;
    logic                       err_timeout;

    logic [107:0] exp_q[$];
    vec_t         tbl[$];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    rib_arbiter #(.NUM_M(4), .PRIO_MASK(4'b1100), .TIMEOUT(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m_req_i       (m_req),
        .m_we_i        (m_we),
        .m_addr_i      (m_addr),
        .m_wdata_i     (m_wdata),
        .m_rdata_o     (m_rdata),
        .m_gnt_o       (m_gnt),
        .m_ready_o     (m_ready),
        .s_req_o       (s_req),
        .s_we_o        (s_we),
        .s_addr_o      (s_addr),
        .s_wdata_o     (s_wdata),
        .s_rdata_i     (s_rdata),
        .s_ready_i     (s_ready),
        .hold_flag_o   (hold_flag),
        .err_timeout_o (err_timeout)
    );

    function automatic vec_t v(input logic rst, input logic [3:0] req, input logic rdy,
                               input logic [31:0] rdata, input logic [3:0] gnt,
                               input logic [3:0] mrdy, input logic sreq, input logic hold,
                               input logic err, input logic [31:0] mrdata);
        vec_t r;
        r.rst = rst; r.req = req; r.rdy = rdy; r.rdata = rdata; r.gnt = gnt;
        r.mrdy = mrdy; r.sreq = sreq; r.hold = hold; r.err = err; r.mrdata = mrdata;
        return r;
    endfunction

    function automatic logic [107:0] expect_of(input vec_t x);
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        we = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (x.gnt[i]) begin
                we    = (i == RIB_M_EX) || (i == RIB_M_JTAG);
                addr  = 32'h1000_0004 + 32'h100 * i;
                wdata = 32'hDEAD_BEEF ^ i;
            end
        end
        return {x.gnt, x.mrdy, x.sreq, we, addr, wdata, x.hold, x.err, x.mrdata};
    endfunction

    task automatic step(input vec_t x, input int tag);
        logic [107:0] got;
        logic [107:0] e;
        @(posedge clk);
        #1;
        rst_n   = x.rst;
        m_req   = x.req;
        s_ready = x.rdy;
        s_rdata = x.rdata;
        exp_q.push_back(expect_of(x));
        @(negedge clk);
        got = {m_gnt, m_ready, s_req, s_we, s_addr, s_wdata, hold_flag, err_timeout, m_rdata};
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL vec%0d got=%h exp=%h (gnt,rdy,sreq,we,addr,wdata,hold,err,rdata)",
                     tag, got, e);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        m_we    = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            m_addr[i]  = 32'h1000_0004 + 32'h100 * i;
            m_wdata[i] = 32'hDEAD_BEEF ^ i;
        end

        step(v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), 0);

        // single master write, ready on third BUSY cycle
        tbl.push_back(v(1, 4'b0001, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 0, 0,            4'b0001, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 0, 0,            4'b0001, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 1, 32'h55,       4'b0001, 4'b0001, 1, 0, 0, 32'h55));
        tbl.push_back(v(1, 4'b0000, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        // round robin between m0/m1, pointer now at 1
        tbl.push_back(v(1, 4'b0011, 1, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 1, 32'hA1,       4'b0010, 4'b0010, 1, 0, 0, 32'hA1));
        tbl.push_back(v(1, 4'b0011, 1, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 1, 32'hB0,       4'b0001, 4'b0001, 1, 0, 0, 32'hB0));
        tbl.push_back(v(1, 4'b0011, 1, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 1, 32'hB1,       4'b0010, 4'b0010, 1, 0, 0, 32'hB1));
        // priority: m3 arrives while m0 busy, no preemption
        tbl.push_back(v(1, 4'b0011, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 0, 0,            4'b0001, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(v(1, 4'b1011, 0, 0,            4'b0001, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(v(1, 4'b1011, 1, 32'hC0,       4'b0001, 4'b0001, 1, 1, 0, 32'hC0));
        tbl.push_back(v(1, 4'b1011, 0, 0,            4'b0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'b1011, 1, 32'hD3,       4'b1000, 4'b1000, 1, 1, 0, 32'hD3));
        tbl.push_back(v(1, 4'b1111, 0, 0,            4'b0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'b1111, 1, 32'hE3,       4'b1000, 4'b1000, 1, 1, 0, 32'hE3));
        tbl.push_back(v(1, 4'b0111, 0, 0,            4'b0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'b0111, 1, 32'hE2,       4'b0100, 4'b0100, 1, 1, 0, 32'hE2));
        // abort by m1 leaves pointer at 1
        tbl.push_back(v(1, 4'b0011, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 0, 0,            4'b0010, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 1, 32'hFF,       4'b0010, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'b0011, 1, 32'hF1,       4'b0010, 4'b0010, 1, 0, 0, 32'hF1));
        tbl.push_back(v(1, 4'b0000, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) step(tbl[k], k + 1);

        // timeout on m2: ready+err in the eighth BUSY cycle, rdata forced to zero
        step(v(1, 4'b0100, 0, 32'hBAD0BAD0, 4'b0000, 4'b0000, 0, 1, 0, 0), 100);
        for (int k = 0; k < 7; k++)
            step(v(1, 4'b0100, 0, 32'hBAD0BAD0, 4'b0100, 4'b0000, 1, 1, 0, 0), 101 + k);
        step(v(1, 4'b0100, 0, 32'hBAD0BAD0, 4'b0100, 4'b0100, 1, 1, 1, 0), 108);
        step(v(1, 4'b0000, 0, 0,            4'b0000, 4'b0000, 0, 0, 0, 0), 109);

        // park the pointer at 1, then reset mid-BUSY and confirm it returns to 0
        step(v(1, 4'b0001, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 0),      200);
        step(v(1, 4'b0001, 1, 32'h77, 4'b0001, 4'b0001, 1, 0, 0, 32'h77), 201);
        step(v(1, 4'b0001, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 0),      202);
        step(v(1, 4'b0001, 0, 0,      4'b0001, 4'b0000, 1, 0, 0, 0),      203);
        step(v(0, 4'b0011, 1, 32'h99, 4'b0000, 4'b0000, 0, 0, 0, 0),      204);
        step(v(1, 4'b0011, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 0),      205);
        step(v(1, 4'b0011, 1, 32'h88, 4'b0001, 4'b0001, 1, 0, 0, 32'h88), 206);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
